// File: rtl/i2c_txn_sequencer.sv
// Expands one high-level I2C request into i2c_master command and write-data beats,
// and frames returned read bytes into a counted stream with tlast and a completion status.
module i2c_txn_sequencer #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           req_address,
    input  logic                 req_read,
    input  logic [LEN_WIDTH-1:0] req_len,
    input  logic                 req_stop,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           s_axis_data_tdata,
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    input  logic                 s_axis_data_tlast,
    output logic [6:0]           m_axis_cmd_address,
    output logic                 m_axis_cmd_start,
    output logic                 m_axis_cmd_read,
    output logic                 m_axis_cmd_write,
    output logic                 m_axis_cmd_write_multiple,
    output logic                 m_axis_cmd_stop,
    output logic                 m_axis_cmd_valid,
    input  logic                 m_axis_cmd_ready,
    output logic [7:0]           m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready,
    output logic                 m_axis_data_tlast,
    input  logic [7:0]           rx_tdata,
    input  logic                 rx_tvalid,
    output logic                 rx_tready,
    output logic [7:0]           out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    input  logic                 missed_ack,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status
);

    typedef enum logic [2:0] {IDLE, CMD_W, DATA_W, CMD_R, WAIT_R, DRAIN, DONE} state_t;

    localparam logic [1:0] ST_OK          = 2'd0;
    localparam logic [1:0] ST_NACK        = 2'd1;
    localparam logic [1:0] ST_LEN_ZERO    = 2'd2;
    localparam logic [1:0] ST_TLAST_EARLY = 2'd3;
    localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 stop_q;
    logic                 nack_q;
    logic [LEN_WIDTH-1:0] cmd_cnt;
    logic [LEN_WIDTH-1:0] data_cnt;
    logic [LEN_WIDTH-1:0] rx_cnt;

    logic [LEN_WIDTH-1:0] last_idx;
    logic [LEN_WIDTH-1:0] cmd_next;
    logic                 cmd_hs;
    logic                 wr_hs;
    logic                 drain_hs;
    logic                 rx_hs;
    logic                 out_hs;
    logic                 nack_now;
    logic                 nack_eff;
    logic                 rx_active;

    assign last_idx  = len_q - ONE;
    assign cmd_next  = cmd_cnt + ONE;
    assign cmd_hs    = m_axis_cmd_valid && m_axis_cmd_ready;
    assign wr_hs     = (state == DATA_W) && s_axis_data_tvalid && m_axis_data_tready;
    assign drain_hs  = (state == DRAIN) && s_axis_data_tvalid;
    assign rx_active = (state == CMD_R) || (state == WAIT_R);
    assign rx_tready = rx_active && (!out_tvalid || out_tready);
    assign rx_hs     = rx_tvalid && rx_tready;
    assign out_hs    = out_tvalid && out_tready;
    assign nack_now  = busy && missed_ack;
    assign nack_eff  = nack_q || nack_now;

    assign m_axis_cmd_start = 1'b0;
    assign m_axis_cmd_write = 1'b0;

    // Write payload is a zero-latency pass-through; DRAIN swallows bytes after a NACK.
    assign m_axis_data_tvalid = (state == DATA_W) && s_axis_data_tvalid;
    assign m_axis_data_tdata  = (state == DATA_W) ? s_axis_data_tdata : 8'h00;
    assign m_axis_data_tlast  = (state == DATA_W) && ((data_cnt == last_idx) || s_axis_data_tlast);
    assign s_axis_data_tready = ((state == DATA_W) && m_axis_data_tready) || (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            req_ready                 <= 1'b0;
            busy                      <= 1'b0;
            done                      <= 1'b0;
            status                    <= ST_OK;
            len_q                     <= '0;
            stop_q                    <= 1'b0;
            nack_q                    <= 1'b0;
            cmd_cnt                   <= '0;
            data_cnt                  <= '0;
            rx_cnt                    <= '0;
            m_axis_cmd_address        <= 7'h00;
            m_axis_cmd_read           <= 1'b0;
            m_axis_cmd_write_multiple <= 1'b0;
            m_axis_cmd_stop           <= 1'b0;
            m_axis_cmd_valid          <= 1'b0;
            out_tdata                 <= 8'h00;
            out_tvalid                <= 1'b0;
            out_tlast                 <= 1'b0;
        end else begin
            done      <= 1'b0;
            req_ready <= 1'b0;
            if (nack_now) begin
                nack_q <= 1'b1;
            end

            if (rx_hs) begin
                out_tdata  <= rx_tdata;
                out_tvalid <= 1'b1;
                out_tlast  <= (rx_cnt == last_idx);
                if (rx_cnt != len_q) begin
                    rx_cnt <= rx_cnt + ONE;
                end
            end else if (out_hs) begin
                out_tvalid <= 1'b0;
                out_tlast  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready                 <= 1'b0;
                        len_q                     <= req_len;
                        stop_q                    <= req_stop;
                        nack_q                    <= 1'b0;
                        cmd_cnt                   <= '0;
                        data_cnt                  <= '0;
                        rx_cnt                    <= '0;
                        status                    <= ST_OK;
                        m_axis_cmd_address        <= req_address;
                        if (req_len == '0) begin
                            status <= ST_LEN_ZERO;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            busy                      <= 1'b1;
                            m_axis_cmd_valid          <= 1'b1;
                            m_axis_cmd_read           <= req_read;
                            m_axis_cmd_write_multiple <= !req_read;
                            m_axis_cmd_stop           <= req_read ? (req_stop && (req_len == ONE)) : req_stop;
                            state                     <= req_read ? CMD_R : CMD_W;
                        end
                    end
                end
                CMD_W: begin
                    if (cmd_hs) begin
                        m_axis_cmd_valid <= 1'b0;
                        state            <= nack_eff ? DRAIN : DATA_W;
                    end
                end
                DATA_W: begin
                    // A byte already offered upstream is allowed to finish before draining.
                    if (wr_hs) begin
                        data_cnt <= data_cnt + ONE;
                        if (data_cnt == last_idx) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (s_axis_data_tlast) begin
                            if (status == ST_OK) begin
                                status <= ST_TLAST_EARLY;
                            end
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (nack_eff) begin
                            state <= DRAIN;
                        end
                    end else if (nack_eff && !s_axis_data_tvalid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_hs) begin
                        data_cnt <= data_cnt + ONE;
                        if ((data_cnt == last_idx) || s_axis_data_tlast) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                CMD_R: begin
                    if (cmd_hs) begin
                        cmd_cnt <= cmd_next;
                        if ((cmd_cnt == last_idx) || nack_eff) begin
                            m_axis_cmd_valid <= 1'b0;
                            state            <= WAIT_R;
                        end else begin
                            m_axis_cmd_stop <= stop_q && (cmd_next == last_idx);
                        end
                    end
                end
                WAIT_R: begin
                    // After a NACK, finish once the output buffer holds nothing more to deliver.
                    if (out_hs && out_tlast) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (nack_eff && (!out_tvalid || out_hs) && !rx_hs) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (nack_now && (status == ST_OK)) begin
                status <= ST_NACK;
            end
        end
    end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Transaction sequencer placed directly upstream of `i2c_master`. It accepts one high-level request (address, direction, byte count, stop) and expands it into the master's AXI-stream command and write-data beats. Write payload comes from the `stream_gen` output. Read bytes returned by the master are re-framed into a counted output stream with `tlast` on the final byte, and the block reports a completion status.

## Interface
Parameters:
- `LEN_WIDTH`, 8, width of the byte-count field; max transfer is 2^LEN_WIDTH-1 bytes.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `req_address`  in  7  target 7-bit I2C address.
- `req_read`  in  1  1 = read, 0 = write.
- `req_len`  in  LEN_WIDTH  byte count.
- `req_stop`  in  1  issue STOP after the last byte.
- `req_valid` / `req_ready`  in / out  1  request handshake.
- `s_axis_data_tdata` / `tvalid` / `tready` / `tlast`  in / in / out / in  8/1/1/1  write payload from upstream.
- `m_axis_cmd_address`  out  7  command address to the master.
- `m_axis_cmd_start` / `read` / `write` / `write_multiple` / `stop`  out  1 each  command flags.
- `m_axis_cmd_valid` / `m_axis_cmd_ready`  out / in  1  command handshake.
- `m_axis_data_tdata` / `tvalid` / `tready` / `tlast`  out / out / in / out  8/1/1/1  write data to the master.
- `rx_tdata` / `rx_tvalid` / `rx_tready`  in / in / out  8/1/1  read data from the master.
- `out_tdata` / `out_tvalid` / `out_tready` / `out_tlast`  out / out / in / out  8/1/1/1  framed read data.
- `missed_ack`  in  1  master NACK indication.
- `busy`  out  1  high from request accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `status`  out  2  0 OK, 1 NACK, 2 LEN_ZERO, 3 TLAST_EARLY. Held until the next request is accepted.

## Operation
- States: IDLE, CMD_W, DATA_W, CMD_R, WAIT_R, DRAIN, DONE.
- IDLE:
  - `req_ready`=1.
  - On accept, latch all `req_*` fields and clear the counters and status.
  - `req_len`==0 → DONE with LEN_ZERO; no command is issued.
  - Otherwise a write goes to CMD_W and a read goes to CMD_R.
- CMD_W:
  - Present one command: `write_multiple`=1, `stop`=latched stop, `start`=0, `read`=`write`=0.
  - On handshake → DATA_W.
- DATA_W:
  - Direct pass-through, with `m_axis_data_tvalid`=`s_axis_data_tvalid` and `s_axis_data_tready`=`m_axis_data_tready`.
  - `m_axis_data_tlast`=1 when byte count==len-1, or when upstream `tlast`=1.
  - Upstream `tlast` before the final byte: forward that byte with `tlast`, set status TLAST_EARLY, → DONE.
  - Upstream `tlast` missing on the final byte is ignored.
  - Final byte handshake → DONE.
- CMD_R:
  - Issue `len` commands, one per byte: `read`=1, `start`=0. `stop`=latched stop only on command index len-1.
  - Commands may run ahead of returned data.
  - After the last command handshake → WAIT_R.
- Read data path:
  - `rx` feeds a one-entry registered output buffer; `rx_tready`=!`out_tvalid` || `out_tready`.
  - `out_tlast`=1 on returned byte index len-1.
  - Active in both CMD_R and WAIT_R. WAIT_R → DONE once the last byte handshakes on `out`.
- `missed_ack` sampled high while `busy`:
  - Status becomes NACK (first error wins).
  - Any asserted valid still completes its handshake.
  - No further commands are issued.
  - Write → DRAIN: consume and discard upstream bytes (`tready`=1) until len bytes total or upstream `tlast`.
  - Read → DONE; no `out_tlast` is generated for missing bytes.
- DONE: `done`=1 for one cycle → IDLE.
- Counters are LEN_WIDTH bits and compared against the latched len; they never wrap within a transaction.

## Timing
- Reset values:
  - State IDLE.
  - All valids, `tlast`, `busy`, `done`=0; `status`=0; `req_ready`=1 one cycle after reset release.
  - Command flags and data buses = 0.
  - Reset mid-transaction abandons it immediately, with no STOP or `done`.
- Accept to first `m_axis_cmd_valid`: 1 cycle. Command outputs are registered, stable while valid && !ready.
- Read commands issue back-to-back, one per cycle, when ready is held high.
- Write data latency is 0 (combinational), so throughput is 1 byte/cycle.
- Read data latency is 1 cycle `rx`→`out`; full throughput with `out_tready`=1.
- Last handshake to `done`: 1 cycle. `req_ready` rises the cycle after `done`.
- `missed_ack` and the final handshake in the same cycle: status NACK, → DONE.

## Test plan
- Write `0x22`, len 4, stop=1, upstream bytes 11 22 33 44 with `tlast` on 44 → one command (`write_multiple`=1, `stop`=1); data 11 22 33 44 with `tlast` only on 44; `done`, status 0.
- Read `0x2A`, len 3, stop=1, master returns A1 B2 C3, `out_tready` toggling 1/0 → 3 read commands, stop only on the third; `out` carries A1 B2 C3 with `tlast` on C3; status 0.
- Write len 4, upstream `tlast` on the 2nd byte → 2 bytes forwarded, the 2nd with `tlast`; status 3.
- Write `0x37`, len 3, `missed_ack` pulsed after byte 1 → remaining bytes drained (not forwarded), status 1, a single `done`.
- Request len 0 → no `m_axis_cmd_valid`; `done` 1 cycle after accept; status 2.
- Reset asserted during DATA_W → all outputs return to reset values next cycle; a new write then completes normally.
